alu_ctrl_decoder: RTL and testbench
===================================

ALU_CTRL_DECODER -- requirements
Module: alu_ctrl_decoder

Interface
REQ-001 Parameters (name, default, meaning): OPERAND_LENGTH, 32, ALU operand/immediate width; PC_LENGTH, 32, program counter width.
REQ-002 One clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 flush  in  1  synchronous discard of all held entries.
REQ-006 instr_valid / instr_ready  in / out  1 / 1  input handshake.
REQ-007 instr  in  32  RV32I instruction word; instr_pc  in  PC_LENGTH  its PC.
REQ-008 out_valid / out_ready  out / in  1 / 1  output handshake.
REQ-009 alu_op_select  out  4;  alu_mux1_select  out  1;  alu_mux2_select  out  2;  alu_pc_select  out  1: ALU controls.
REQ-010 imm  out  OPERAND_LENGTH  sign-extended immediate; use_imm  out  1  immediate replaces opd2; pc_out  out  PC_LENGTH  forwarded instr_pc; illegal  out  1  unsupported encoding.

Function
REQ-011 Transfer occurs on a rising edge with valid&&ready on the respective side.
REQ-012 Two-entry buffer (main, skid); states EMPTY (out_valid=0, instr_ready=1), ONE (1,1), TWO (1,0); instr_ready is a registered output.
REQ-013 Transitions: EMPTY+accept->ONE; ONE+accept+no drain->TWO; ONE+accept+drain->ONE (new entry in main); ONE+drain only->EMPTY; TWO+drain->ONE (skid moves to main); otherwise hold.
REQ-014 Latency: accept in cycle N -> out_valid with decoded fields in cycle N+1 when EMPTY; full throughput of one instruction/cycle with out_ready=1.
REQ-015 All outputs stable while out_valid=1 and out_ready=0; order strictly preserved.
REQ-016 flush=1: next state EMPTY; flush wins over simultaneous accept and drain; the instruction offered that cycle is dropped.
REQ-017 alu_mux2_select: 00 adder, 01 logic, 10 shifter, 11 comparison; alu_mux1_select 0 = opd1/opd2, 1 = opd3/opd4.
REQ-018 OP (0110011), funct7 0000000 unless noted: ADD 00/0000; SUB (f7 0100000) 00/1000; SLL 10/0011; SLT 11/0011; SLTU 11/0111; XOR 01/0100; SRL 10/0001; SRA (f7 0100000) 10/0111; OR 01/0110; AND 01/0111; use_imm=0.
REQ-019 OP-IMM (0010011): same mapping as OP by funct3, ADDI never SUB; shifts check funct7 as OP; use_imm=1, imm = I-immediate (shamt in imm[4:0]).
REQ-020 BRANCH (1100011): mux2=11, mux1=1, pc_select=1, imm = B-immediate; funct3 000 EQ 0000, 001 NE 0001, 100 LT 0011, 101 GE 0010, 110 LTU 0111, 111 GEU 0110.
REQ-021 LOAD/JALR (I-imm), STORE (S-imm): adder 00/0000, use_imm=1, pc_select=0; AUIPC (U-imm), JAL (J-imm): adder 00/0000, use_imm=1, pc_select=1.
REQ-022 Immediates sign-extended from bit 31, truncated to OPERAND_LENGTH LSBs when narrower.
REQ-023 Any other opcode, BRANCH funct3 010/011, or bad funct7 on OP/shift: illegal=1, all ALU controls, imm, use_imm = 0; entry still traverses the handshake; pc_out valid.

Reset
REQ-024 rst_n low: state EMPTY, out_valid=0, instr_ready=0, all data outputs 0, illegal=0, immediately and independent of clk.
REQ-025 instr_ready rises on the first clk edge after rst_n deasserts; reset mid-operation discards both entries.

Verification
REQ-026 instr=0x002081B3 (ADD), pc 0x100, out_ready=1 -> next cycle out_valid=1, mux2=00, op=0000, mux1=0, pc_sel=0, use_imm=0, pc_out=0x100, illegal=0.
REQ-027 instr=0x402081B3 -> op=1000; instr=0x4030D093 (SRAI x1,x1,3) -> mux2=10, op=0111, use_imm=1, imm=0x00000403.
REQ-028 instr=0xFE20FEE3 (BGEU x1,x2,-4) -> mux2=11, mux1=1, op=0110, pc_sel=1, imm=0xFFFFFFFC.
REQ-029 out_ready=0, three back-to-back valid instructions A,B,C -> A,B accepted, instr_ready=0 from the cycle after B, outputs hold A; out_ready=1 -> A, B, then C emerge in order, no loss/duplication.
REQ-030 instr=0x0000000B and BRANCH with funct3 010 -> illegal=1, controls/imm=0; flush in TWO with instr_valid=1 -> next cycle out_valid=0, instr_ready=1, offered instruction never emerges.
REQ-031 rst_n pulsed low in TWO between edges -> out_valid=0 and instr_ready=0 immediately; after release, first accepted instruction appears with one-cycle latency.

Source files
------------

// File: rtl/alu_ctrl_decoder_if.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decoder_if
// Bundles the instruction-side handshake, the decoded-output handshake and the
// pipeline flush of alu_ctrl_decoder.
//   master : upstream/downstream environment (drives instr side, out_ready, flush)
//   slave  : the decoder itself
// Signals:
//   flush                      synchronous discard of all held entries
//   instr_valid / instr_ready  instruction handshake
//   instr, instr_pc            RV32I instruction word and its PC
//   out_valid / out_ready      decoded-output handshake
//   alu_op_select, alu_mux1_select, alu_mux2_select, alu_pc_select  ALU controls
//   imm, use_imm, pc_out, illegal                                   decoded data
// -----------------------------------------------------------------------------
interface alu_ctrl_decoder_if #(
   parameter int OPERAND_LENGTH = 32,
   parameter int PC_LENGTH      = 32
);
   logic                      flush;
   logic                      instr_valid;
   logic                      instr_ready;
   logic [31:0]               instr;
   logic [PC_LENGTH-1:0]      instr_pc;
   logic                      out_valid;
   logic                      out_ready;
   logic [3:0]                alu_op_select;
   logic                      alu_mux1_select;
   logic [1:0]                alu_mux2_select;
   logic                      alu_pc_select;
   logic [OPERAND_LENGTH-1:0] imm;
   logic                      use_imm;
   logic [PC_LENGTH-1:0]      pc_out;
   logic                      illegal;

   modport master (
      output flush, instr_valid, instr, instr_pc, out_ready,
      input  instr_ready, out_valid, alu_op_select, alu_mux1_select,
             alu_mux2_select, alu_pc_select, imm, use_imm, pc_out, illegal
   );

   modport slave (
      input  flush, instr_valid, instr, instr_pc, out_ready,
      output instr_ready, out_valid, alu_op_select, alu_mux1_select,
             alu_mux2_select, alu_pc_select, imm, use_imm, pc_out, illegal
   );
endinterface

// File: rtl/alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// alu_ctrl_decoder
// Decodes RV32I instruction words into ALU control fields and a sign-extended
// immediate, behind a two-entry (main + skid) valid/ready buffer so the
// upstream sees a registered instr_ready and still gets one instruction per
// cycle when the downstream never stalls.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears both entries and all outputs)
//   bus    alu_ctrl_decoder_if.slave: flush, instruction handshake, decoded
//          output handshake and fields. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module alu_ctrl_decoder #(
   parameter int OPERAND_LENGTH = 32,
   parameter int PC_LENGTH      = 32
) (
   input logic               clk,
   input logic               rst_n,
   alu_ctrl_decoder_if.slave bus
);

   // Width used to sign-extend a 32-bit immediate before fitting it.
   localparam int IMM_W = (OPERAND_LENGTH > 32) ? OPERAND_LENGTH : 32;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic                      illegal;
      logic [3:0]                op;
      logic                      mux1;
      logic [1:0]                mux2;
      logic                      pc_sel;
      logic                      use_imm;
      logic [OPERAND_LENGTH-1:0] imm;
      logic [PC_LENGTH-1:0]      pc;
   } entry_t;

   // ---------------------------------------------------------------------------
   // Immediate helpers (32-bit RV32I formats)
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] imm_i(input logic [31:0] w);
      return {{20{w[31]}}, w[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] w);
      return {{20{w[31]}}, w[31:25], w[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] w);
      return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] w);
      return {w[31:12], 12'h000};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] w);
      return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
   endfunction

   // Sign-extends from bit 31 when the operand is wider, keeps LSBs when narrower.
   function automatic logic [OPERAND_LENGTH-1:0] fit_imm(input logic [31:0] v);
      logic [IMM_W-1:0] t;
      t = {{(IMM_W - 31){v[31]}}, v[30:0]};
      return t[OPERAND_LENGTH-1:0];
   endfunction

   // Returns {legal, mux2[1:0], op[3:0]} for OP (is_reg=1) / OP-IMM (is_reg=0).
   // OP-IMM ignores funct7 except on shifts, where it holds the shift type.
   function automatic logic [6:0] alu_fields(input logic [2:0] f3,
                                             input logic [6:0] f7,
                                             input logic       is_reg);
      logic       f7_zero;
      logic       f7_alt;
      logic       f7_ok;
      logic [6:0] r;
      f7_zero = (f7 == 7'b0000000);
      f7_alt  = (f7 == 7'b0100000);
      f7_ok   = f7_zero || !is_reg;
      r       = 7'b0000000;
      case (f3)
         3'b000: begin
            if (!is_reg || f7_zero) begin
               r = {1'b1, 2'b00, 4'b0000};
            end else if (f7_alt) begin
               r = {1'b1, 2'b00, 4'b1000};
            end else begin
               r = 7'b0000000;
            end
         end
         3'b001: r = f7_zero ? {1'b1, 2'b10, 4'b0011} : 7'b0000000;
         3'b010: r = f7_ok   ? {1'b1, 2'b11, 4'b0011} : 7'b0000000;
         3'b011: r = f7_ok   ? {1'b1, 2'b11, 4'b0111} : 7'b0000000;
         3'b100: r = f7_ok   ? {1'b1, 2'b01, 4'b0100} : 7'b0000000;
         3'b101: begin
            if (f7_zero) begin
               r = {1'b1, 2'b10, 4'b0001};
            end else if (f7_alt) begin
               r = {1'b1, 2'b10, 4'b0111};
            end else begin
               r = 7'b0000000;
            end
         end
         3'b110: r = f7_ok   ? {1'b1, 2'b01, 4'b0110} : 7'b0000000;
         3'b111: r = f7_ok   ? {1'b1, 2'b01, 4'b0111} : 7'b0000000;
         default: r = 7'b0000000;
      endcase
      return r;
   endfunction

   // Returns {legal, op[3:0]} for the BRANCH comparator.
   function automatic logic [4:0] branch_fields(input logic [2:0] f3);
      logic [4:0] r;
      case (f3)
         3'b000:  r = {1'b1, 4'b0000};
         3'b001:  r = {1'b1, 4'b0001};
         3'b100:  r = {1'b1, 4'b0011};
         3'b101:  r = {1'b1, 4'b0010};
         3'b110:  r = {1'b1, 4'b0111};
         3'b111:  r = {1'b1, 4'b0110};
         default: r = 5'b00000;
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Signals
   // ---------------------------------------------------------------------------
   state_t     state_r;
   state_t     state_s;
   logic       instr_ready_r;
   logic       out_valid_r;
   entry_t     main_r;
   entry_t     skid_r;
   entry_t     dec_s;
   logic [6:0] alu_s;
   logic [4:0] br_s;
   logic       accept_s;
   logic       drain_s;
   logic       load_main_dec_s;
   logic       load_main_skid_s;
   logic       load_skid_s;
   logic [6:0] opcode_s;
   logic [2:0] funct3_s;
   logic [6:0] funct7_s;

   assign opcode_s = bus.instr[6:0];
   assign funct3_s = bus.instr[14:12];
   assign funct7_s = bus.instr[31:25];
   assign accept_s = bus.instr_valid && instr_ready_r;
   assign drain_s  = out_valid_r && bus.out_ready;

   // Decode the offered instruction into a buffer entry.
   always_comb begin
      dec_s    = '0;
      dec_s.pc = bus.instr_pc;
      alu_s    = 7'b0000000;
      br_s     = 5'b00000;
      case (opcode_s)
         OPC_OP: begin
            alu_s = alu_fields(funct3_s, funct7_s, 1'b1);
            if (alu_s[6]) begin
               dec_s.mux2 = alu_s[5:4];
               dec_s.op   = alu_s[3:0];
            end else begin
               dec_s.illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            alu_s = alu_fields(funct3_s, funct7_s, 1'b0);
            if (alu_s[6]) begin
               dec_s.mux2    = alu_s[5:4];
               dec_s.op      = alu_s[3:0];
               dec_s.use_imm = 1'b1;
               dec_s.imm     = fit_imm(imm_i(bus.instr));
            end else begin
               dec_s.illegal = 1'b1;
            end
         end
         OPC_BRANCH: begin
            br_s = branch_fields(funct3_s);
            if (br_s[4]) begin
               dec_s.mux2   = 2'b11;
               dec_s.mux1   = 1'b1;
               dec_s.pc_sel = 1'b1;
               dec_s.op     = br_s[3:0];
               dec_s.imm    = fit_imm(imm_b(bus.instr));
            end else begin
               dec_s.illegal = 1'b1;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            dec_s.use_imm = 1'b1;
            dec_s.imm     = fit_imm(imm_i(bus.instr));
         end
         OPC_STORE: begin
            dec_s.use_imm = 1'b1;
            dec_s.imm     = fit_imm(imm_s(bus.instr));
         end
         OPC_AUIPC: begin
            dec_s.use_imm = 1'b1;
            dec_s.pc_sel  = 1'b1;
            dec_s.imm     = fit_imm(imm_u(bus.instr));
         end
         OPC_JAL: begin
            dec_s.use_imm = 1'b1;
            dec_s.pc_sel  = 1'b1;
            dec_s.imm     = fit_imm(imm_j(bus.instr));
         end
         default: begin
            dec_s.illegal = 1'b1;
         end
      endcase
   end

   // Buffer occupancy next-state and entry load enables; flush overrides all.
   always_comb begin
      state_s          = state_r;
      load_main_dec_s  = 1'b0;
      load_main_skid_s = 1'b0;
      load_skid_s      = 1'b0;
      if (bus.flush) begin
         state_s = ST_EMPTY;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_s         = ST_ONE;
                  load_main_dec_s = 1'b1;
               end else begin
                  state_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && drain_s) begin
                  state_s         = ST_ONE;
                  load_main_dec_s = 1'b1;
               end else if (accept_s) begin
                  state_s     = ST_TWO;
                  load_skid_s = 1'b1;
               end else if (drain_s) begin
                  state_s = ST_EMPTY;
               end else begin
                  state_s = ST_ONE;
               end
            end
            ST_TWO: begin
               // instr_ready is low here, so only a drain can happen.
               if (drain_s) begin
                  state_s          = ST_ONE;
                  load_main_skid_s = 1'b1;
               end else begin
                  state_s = ST_TWO;
               end
            end
            default: begin
               state_s = ST_EMPTY;
            end
         endcase
      end
   end

   // State register plus registered handshake outputs derived from next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_EMPTY;
         instr_ready_r <= 1'b0;
         out_valid_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         instr_ready_r <= (state_s != ST_TWO);
         out_valid_r   <= (state_s != ST_EMPTY);
      end
   end

   // Main and skid entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_r <= '0;
         skid_r <= '0;
      end else begin
         if (load_main_dec_s) begin
            main_r <= dec_s;
         end else if (load_main_skid_s) begin
            main_r <= skid_r;
         end else begin
            main_r <= main_r;
         end
         if (load_skid_s) begin
            skid_r <= dec_s;
         end else begin
            skid_r <= skid_r;
         end
      end
   end

   assign bus.instr_ready     = instr_ready_r;
   assign bus.out_valid       = out_valid_r;
   assign bus.alu_op_select   = main_r.op;
   assign bus.alu_mux1_select = main_r.mux1;
   assign bus.alu_mux2_select = main_r.mux2;
   assign bus.alu_pc_select   = main_r.pc_sel;
   assign bus.imm             = main_r.imm;
   assign bus.use_imm         = main_r.use_imm;
   assign bus.pc_out          = main_r.pc;
   assign bus.illegal         = main_r.illegal;

endmodule

// File: tb/tb_alu_ctrl_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_decoder
// Directed vectors with hand-computed decode results. The driver pushes the
// expected entry when the instruction is accepted; an independent monitor pops
// and compares whenever the decoder transfers an output.
// ctl packing: {op[3:0], mux2[1:0], mux1, pc_sel, use_imm, illegal}
// -----------------------------------------------------------------------------
module tb_alu_ctrl_decoder;

   typedef struct packed {
      logic [9:0]  ctl;
      logic [31:0] imm;
      logic [31:0] pc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   exp_t q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_ctrl_decoder_if #(.OPERAND_LENGTH(32), .PC_LENGTH(32)) bus ();

   alu_ctrl_decoder #(.OPERAND_LENGTH(32), .PC_LENGTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [9:0] mkc(input logic [3:0] op, input logic [1:0] m2,
                                      input logic m1, input logic ps,
                                      input logic ui, input logic il);
      return {op, m2, m1, ps, ui, il};
   endfunction

   function automatic logic [9:0] out_ctl();
      return {bus.alu_op_select, bus.alu_mux2_select, bus.alu_mux1_select,
              bus.alu_pc_select, bus.use_imm, bus.illegal};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
      n_vec++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   // Scoreboard monitor: compare on every output transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL unexpected_output: got pc %h, required no output", bus.pc_out);
            end else begin
               e = q.pop_front();
               chk("ctl", {54'd0, out_ctl()}, {54'd0, e.ctl});
               chk("imm", {32'd0, bus.imm}, {32'd0, e.imm});
               chk("pc_out", {32'd0, bus.pc_out}, {32'd0, e.pc});
            end
         end
      end
   end

   // Offer one instruction; record expectation when it is accepted.
   task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [9:0] c, input logic [31:0] im, output int waits);
      bit got;
      got   = 1'b0;
      waits = 0;
      bus.instr_valid = 1'b1;
      bus.instr       = ins;
      bus.instr_pc    = pc;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (bus.instr_ready) begin
            q.push_back({c, im, pc});
            got = 1'b1;
         end else begin
            waits++;
         end
      end
      if (!got) begin
         n_vec++;
         n_fail++;
         $display("FAIL accept_timeout: got no instr_ready for pc %h, required accept", pc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      chk("queue_empty", 64'(q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   // Directed decode vectors
   logic [31:0] v_ins [16];
   logic [9:0]  v_ctl [16];
   logic [31:0] v_imm [16];

   initial begin
      v_ins[0]  = 32'h002081B3; v_ctl[0]  = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); v_imm[0]  = 32'h0;          // ADD
      v_ins[1]  = 32'h402081B3; v_ctl[1]  = mkc(4'b1000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); v_imm[1]  = 32'h0;          // SUB
      v_ins[2]  = 32'h4030D093; v_ctl[2]  = mkc(4'b0111, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0); v_imm[2]  = 32'h00000403;   // SRAI
      v_ins[3]  = 32'hFE20FEE3; v_ctl[3]  = mkc(4'b0110, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0); v_imm[3]  = 32'hFFFFFFFC;   // BGEU
      v_ins[4]  = 32'h0020E1B3; v_ctl[4]  = mkc(4'b0110, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0); v_imm[4]  = 32'h0;          // OR
      v_ins[5]  = 32'hFFF00093; v_ctl[5]  = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0); v_imm[5]  = 32'hFFFFFFFF;   // ADDI -1
      v_ins[6]  = 32'h00812083; v_ctl[6]  = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0); v_imm[6]  = 32'h00000008;   // LW
      v_ins[7]  = 32'hFE20AE23; v_ctl[7]  = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0); v_imm[7]  = 32'hFFFFFFFC;   // SW
      v_ins[8]  = 32'h008000EF; v_ctl[8]  = mkc(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0); v_imm[8]  = 32'h00000008;   // JAL
      v_ins[9]  = 32'h12345097; v_ctl[9]  = mkc(4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0); v_imm[9]  = 32'h12345000;   // AUIPC
      v_ins[10] = 32'h0020B1B3; v_ctl[10] = mkc(4'b0111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); v_imm[10] = 32'h0;          // SLTU
      v_ins[11] = 32'h0000000B; v_ctl[11] = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); v_imm[11] = 32'h0;          // custom opcode
      v_ins[12] = 32'h0020A063; v_ctl[12] = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); v_imm[12] = 32'h0;          // BRANCH f3=010
      v_ins[13] = 32'h0220B1B3; v_ctl[13] = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); v_imm[13] = 32'h0;          // OP bad funct7
      v_ins[14] = 32'h40109093; v_ctl[14] = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); v_imm[14] = 32'h0;          // SLLI bad funct7
      v_ins[15] = 32'h123450B7; v_ctl[15] = mkc(4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1); v_imm[15] = 32'h0;          // LUI unsupported
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      int wsum;
      rst_n           = 1'b0;
      bus.flush       = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = 32'h0;
      bus.instr_pc    = 32'h0;
      bus.out_ready   = 1'b0;

      // Reset state
      #3;
      chk("reset_handshake", {62'd0, bus.out_valid, bus.instr_ready}, 64'd0);
      chk("reset_ctl", {54'd0, out_ctl()}, 64'd0);
      chk("reset_data", {bus.imm, bus.pc_out}, 64'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge", {63'd0, bus.instr_ready}, 64'd0);
      @(posedge clk);
      #1;
      chk("ready_after_edge", {63'd0, bus.instr_ready}, 64'd1);

      // Full-throughput decode burst
      bus.out_ready = 1'b1;
      wsum = 0;
      for (int i = 0; i < 16; i++) begin
         send(v_ins[i], 32'h100 + 32'(i * 4), v_ctl[i], v_imm[i], w);
         wsum += w;
      end
      bus.instr_valid = 1'b0;
      chk("throughput_waits", 64'(wsum), 64'd0);
      drain();

      // Back-pressure: A, B buffered, C waits, then in-order release
      bus.out_ready = 1'b0;
      send(v_ins[0], 32'h200, v_ctl[0], v_imm[0], w);
      send(v_ins[1], 32'h204, v_ctl[1], v_imm[1], w);
      bus.instr    = v_ins[4];
      bus.instr_pc = 32'h208;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_handshake", {62'd0, bus.instr_ready, bus.out_valid}, 64'd1);
         chk("stall_hold", {22'd0, out_ctl(), bus.pc_out}, {22'd0, v_ctl[0], 32'h200});
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(v_ins[4], 32'h208, v_ctl[4], v_imm[4], w);
      bus.instr_valid = 1'b0;
      drain();

      // Flush while TWO, offered instruction dropped
      bus.out_ready = 1'b0;
      send(v_ins[9], 32'h300, v_ctl[9], v_imm[9], w);
      send(v_ins[8], 32'h304, v_ctl[8], v_imm[8], w);
      bus.flush    = 1'b1;
      bus.instr    = v_ins[6];
      bus.instr_pc = 32'h308;
      @(posedge clk);
      #1;
      bus.flush       = 1'b0;
      bus.instr_valid = 1'b0;
      q.delete();
      chk("flush_two", {62'd0, bus.out_valid, bus.instr_ready}, 64'd1);

      // Flush while ONE with an acceptable offer: flush wins
      send(v_ins[5], 32'h310, v_ctl[5], v_imm[5], w);
      bus.flush    = 1'b1;
      bus.instr    = v_ins[7];
      bus.instr_pc = 32'h314;
      @(posedge clk);
      #1;
      bus.flush       = 1'b0;
      bus.instr_valid = 1'b0;
      q.delete();
      chk("flush_one", {62'd0, bus.out_valid, bus.instr_ready}, 64'd1);
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("flush_no_output", {63'd0, bus.out_valid}, 64'd0);
      send(v_ins[2], 32'h320, v_ctl[2], v_imm[2], w);
      bus.instr_valid = 1'b0;
      drain();

      // Asynchronous reset in TWO
      bus.out_ready = 1'b0;
      send(v_ins[9], 32'h400, v_ctl[9], v_imm[9], w);
      send(v_ins[7], 32'h404, v_ctl[7], v_imm[7], w);
      bus.instr_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_handshake", {62'd0, bus.out_valid, bus.instr_ready}, 64'd0);
      chk("async_rst_ctl", {54'd0, out_ctl()}, 64'd0);
      chk("async_rst_data", {bus.imm, bus.pc_out}, 64'd0);
      q.delete();
      @(posedge clk);
      #3;
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_rst", {63'd0, bus.instr_ready}, 64'd1);
      send(v_ins[3], 32'h500, v_ctl[3], v_imm[3], w);
      bus.instr_valid = 1'b0;
      chk("latency_one", {63'd0, bus.out_valid}, 64'd1);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
